fmc_bus_seq: RTL and testbench

FMC_BUS_SEQ -- requirements
Module: fmc_bus_seq

---
 rtl/fmc_pkg.sv | 15 +
 rtl/fmc_rd_timer.sv | 34 +++
 rtl/fmc_bus_seq.sv | 170 +++++++++++++++++
 tb/tb_fmc_bus_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmc_pkg.sv
// Shared constants and state encoding for the FMC bus sequencer.
package fmc_pkg;

  localparam int unsigned FMC_ADDR_W = 25;
  localparam int unsigned FMC_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CAP,
    ST_RD_REQ,
    ST_RD_DRV,
    ST_RECOVER
  } fmc_state_e;

endpackage

// File: rtl/fmc_rd_timer.sv
// Read-wait timer: counts cycles while enabled, flags the LIMIT-th enabled cycle.
module fmc_rd_timer #(
  parameter int unsigned LIMIT = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  // Expiry is combinational so the sequencer can act on the same edge.
  assign expired_o = en_i && !clr_i && (cnt_q == 8'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fmc_bus_seq.sv
// FMC slave bus sequencer: turns synchronized NE/NOE/NWE into register-map strobes.
// Optional read timeout enabled by defining FMC_RD_TIMEOUT_EN.
module fmc_bus_seq
  import fmc_pkg::*;
#(
  parameter int unsigned              RD_TIMEOUT   = 32,
  parameter logic [FMC_DATA_W-1:0]    TIMEOUT_DATA = 16'hBAD0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cs_n_i,
  input  logic                  rd_n_i,
  input  logic                  wr_n_i,
  input  logic [FMC_ADDR_W-1:0] addr_i,
  input  logic [FMC_DATA_W-1:0] data_i,
  output logic                  wr_en_o,
  output logic [FMC_ADDR_W-1:0] wr_addr_o,
  output logic [FMC_DATA_W-1:0] wr_data_o,
  output logic                  rd_req_o,
  output logic [FMC_ADDR_W-1:0] rd_addr_o,
  input  logic                  rd_ack_i,
  input  logic [FMC_DATA_W-1:0] rd_data_i,
  output logic [FMC_DATA_W-1:0] data_o,
  output logic                  tri_en_o,
  output logic                  busy_o,
  output logic                  err_o
);

  fmc_state_e            state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [FMC_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [FMC_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                  rd_req_q, rd_req_d;
  logic [FMC_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [FMC_DATA_W-1:0] data_q, data_d;
  logic                  tri_en_q, tri_en_d;
  logic                  busy_q, busy_d;
  logic                  wr_strobe, rd_strobe;

  assign wr_strobe = !cs_n_i && !wr_n_i;
  assign rd_strobe = !cs_n_i && !rd_n_i;

`ifdef FMC_RD_TIMEOUT_EN
  logic err_q, err_d;
  logic rd_expired;

  fmc_rd_timer #(
    .LIMIT (RD_TIMEOUT)
  ) u_rd_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q != ST_RD_REQ),
    .en_i      (state_q == ST_RD_REQ),
    .expired_o (rd_expired)
  );

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    tri_en_d  = 1'b0;
`ifdef FMC_RD_TIMEOUT_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (wr_strobe) begin
          state_d   = ST_WR_CAP;
          wr_addr_d = addr_i;
          wr_data_d = data_i;
        end else if (rd_strobe) begin
          state_d   = ST_RD_REQ;
          rd_addr_d = addr_i;
          rd_req_d  = 1'b1;
        end
      end
      ST_WR_CAP: begin
        if (wr_strobe) begin
          wr_addr_d = addr_i;
          wr_data_d = data_i;
        end else begin
          wr_en_d = 1'b1;
          state_d = ST_RECOVER;
        end
      end
      ST_RD_REQ: begin
        // Abort outranks a coincident ack so the pad is never driven after NOE rises.
        if (!rd_strobe) begin
          state_d = ST_RECOVER;
        end else if (rd_ack_i) begin
          data_d   = rd_data_i;
          tri_en_d = 1'b1;
          state_d  = ST_RD_DRV;
`ifdef FMC_RD_TIMEOUT_EN
        end else if (rd_expired) begin
          data_d   = TIMEOUT_DATA;
          tri_en_d = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_RD_DRV;
`endif
        end else begin
          rd_req_d = 1'b1;
        end
      end
      ST_RD_DRV: begin
        if (rd_strobe) begin
          tri_en_d = 1'b1;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (rd_n_i && wr_n_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
      tri_en_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FMC_RD_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      tri_en_q  <= tri_en_d;
      busy_q    <= busy_d;
`ifdef FMC_RD_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_req_o  = rd_req_q;
  assign rd_addr_o = rd_addr_q;
  assign data_o    = data_q;
  assign tri_en_o  = tri_en_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_fmc_bus_seq.sv
// Directed self-checking bench for fmc_bus_seq (timeout case runs when FMC_RD_TIMEOUT_EN is defined).
module tb_fmc_bus_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n, rd_n, wr_n;
  logic [24:0] addr;
  logic [15:0] wdata;
  logic        wr_en;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic [15:0] data_out;
  logic        tri_en, busy, err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses = 0;
  int rd_rises  = 0;
  int tri_cycles = 0;
  logic rd_req_prev = 1'b0;
  int p0, r0, t0;

  fmc_bus_seq #(
    .RD_TIMEOUT   (4),
    .TIMEOUT_DATA (16'hBAD0)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cs_n_i    (cs_n),
    .rd_n_i    (rd_n),
    .wr_n_i    (wr_n),
    .addr_i    (addr),
    .data_i    (wdata),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .rd_req_o  (rd_req),
    .rd_addr_o (rd_addr),
    .rd_ack_i  (rd_ack),
    .rd_data_i (rd_data),
    .data_o    (data_out),
    .tri_en_o  (tri_en),
    .busy_o    (busy),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_pulses++;
    if (rd_req && !rd_req_prev) rd_rises++;
    rd_req_prev = rd_req;
    if (tri_en) tri_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = '0; wdata = '0; rd_ack = 1'b0; rd_data = '0;
    tick(3);
    check("rst_wr_en",   32'(wr_en),   32'd0);
    check("rst_rd_req",  32'(rd_req),  32'd0);
    check("rst_tri_en",  32'(tri_en),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_data",    32'(data_out), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    tick(1);

    // Write: 4 cycles of NWE low, then release
    p0 = wr_pulses;
    cs_n = 1'b0; wr_n = 1'b0; addr = 25'h10; wdata = 16'hA5A5;
    tick(4);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_no_early_pulse", 32'(wr_pulses - p0), 32'd0);
    wr_n = 1'b1; cs_n = 1'b1; addr = 25'h1FF; wdata = 16'h0000;
    tick(1);
    check("wr_en_pulse", 32'(wr_en),   32'd1);
    check("wr_addr",     32'(wr_addr), 32'h10);
    check("wr_data",     32'(wr_data), 32'hA5A5);
    tick(2);
    check("wr_pulse_count", 32'(wr_pulses - p0), 32'd1);
    check("wr_idle", 32'(busy), 32'd0);

    // Read with ack after 3 cycles
    cs_n = 1'b0; rd_n = 1'b0; addr = 25'h22;
    tick(1);
    check("rd_req_on",  32'(rd_req),  32'd1);
    check("rd_addr",    32'(rd_addr), 32'h22);
    check("rd_tri_off", 32'(tri_en),  32'd0);
    tick(2);
    check("rd_req_hold", 32'(rd_req), 32'd1);
    rd_ack = 1'b1; rd_data = 16'h1234;
    tick(1);
    rd_ack = 1'b0; rd_data = 16'hFFFF;
    check("rd_tri_on",   32'(tri_en),   32'd1);
    check("rd_data_o",   32'(data_out), 32'h1234);
    check("rd_req_drop", 32'(rd_req),   32'd0);
    tick(3);
    check("rd_tri_hold", 32'(tri_en),   32'd1);
    check("rd_data_hold", 32'(data_out), 32'h1234);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(1);
    check("rd_tri_release", 32'(tri_en), 32'd0);
    tick(1);
    check("rd_idle", 32'(busy), 32'd0);

    // Abort before ack, then a late ack
    t0 = tri_cycles;
    cs_n = 1'b0; rd_n = 1'b0; addr = 25'h33;
    tick(2);
    check("ab_req_on", 32'(rd_req), 32'd1);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(1);
    check("ab_req_drop", 32'(rd_req), 32'd0);
    rd_ack = 1'b1; rd_data = 16'h7777;
    tick(2);
    rd_ack = 1'b0;
    check("ab_tri_never", 32'(tri_cycles - t0), 32'd0);
    check("ab_data_kept", 32'(data_out), 32'h1234);
    check("ab_idle",      32'(busy), 32'd0);
    check("ab_err",       32'(err),  32'd0);

    // Back-to-back with NE held low
    p0 = wr_pulses; r0 = rd_rises;
    cs_n = 1'b0; wr_n = 1'b0; addr = 25'h1; wdata = 16'hBEEF;
    tick(2);
    wr_n = 1'b1;
    tick(1);
    check("bb_wr_en",   32'(wr_en),   32'd1);
    check("bb_wr_addr", 32'(wr_addr), 32'h1);
    check("bb_wr_data", 32'(wr_data), 32'hBEEF);
    tick(1);
    rd_n = 1'b0; addr = 25'h2;
    tick(1);
    check("bb_rd_req",  32'(rd_req),  32'd1);
    check("bb_rd_addr", 32'(rd_addr), 32'h2);
    rd_ack = 1'b1; rd_data = 16'h5678;
    tick(1);
    rd_ack = 1'b0;
    check("bb_rd_data", 32'(data_out), 32'h5678);
    rd_n = 1'b1;
    tick(2);
    cs_n = 1'b1;
    tick(1);
    check("bb_wr_count", 32'(wr_pulses - p0), 32'd1);
    check("bb_rd_count", 32'(rd_rises - r0),  32'd1);

`ifdef FMC_RD_TIMEOUT_EN
    // Timeout with RD_TIMEOUT=4
    cs_n = 1'b0; rd_n = 1'b0; addr = 25'h5;
    tick(1);
    check("to_req_on", 32'(rd_req), 32'd1);
    tick(3);
    check("to_req_wait", 32'(rd_req), 32'd1);
    check("to_err_pre",  32'(err),    32'd0);
    tick(1);
    check("to_data",  32'(data_out), 32'hBAD0);
    check("to_err",   32'(err),      32'd1);
    check("to_tri",   32'(tri_en),   32'd1);
    check("to_req_drop", 32'(rd_req), 32'd0);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(2);
    check("to_err_sticky", 32'(err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
`else
    // No timeout: request waits indefinitely
    cs_n = 1'b0; rd_n = 1'b0; addr = 25'h5;
    tick(12);
    check("nt_req_wait", 32'(rd_req), 32'd1);
    check("nt_err",      32'(err),    32'd0);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(2);
    check("nt_idle", 32'(busy), 32'd0);
`endif

    // Reset while driving read data
    cs_n = 1'b0; rd_n = 1'b0; addr = 25'h44;
    tick(1);
    rd_ack = 1'b1; rd_data = 16'h9999;
    tick(1);
    rd_ack = 1'b0;
    check("rr_tri_on", 32'(tri_en), 32'd1);
    p0 = wr_pulses;
    rst = 1'b1;
    tick(1);
    check("rr_tri_off", 32'(tri_en),   32'd0);
    check("rr_busy",    32'(busy),     32'd0);
    check("rr_data",    32'(data_out), 32'd0);
    check("rr_err",     32'(err),      32'd0);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    check("rr_no_wr", 32'(wr_pulses - p0), 32'd0);
    check("rr_idle",  32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
